tv_checker: RTL
===============

TV_CHECKER -- requirements
Module: tv_checker

Interface
REQ-001 SHALL declare parameter IN_W, default 8: width of stimulus applied to the DUT.
REQ-002 SHALL declare parameter OUT_W, default 8: width of the DUT response compared.
REQ-003 SHALL declare parameter DEPTH, default 16: vector memory entries, range 2..1024.
REQ-004 SHALL declare parameter LAT, default 1: DUT latency in cycles, range 0..7.
REQ-005 SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ld_we  in  1  write one vector into memory.
- ld_addr  in  AW=$clog2(DEPTH)  vector memory write address.
- ld_data  in  IN_W+2*OUT_W  packed {stim, expected, mask}; the mask field is ignored when masking is compiled out.
- num_vec  in  AW+1  number of vectors to run, sampled on start.
- start  in  1  one-cycle pulse that begins a run.
- abort  in  1  ends a run immediately.
- dut_in  out  IN_W  stimulus to the DUT, registered.
- dut_out  in  OUT_W  response from the DUT.
- busy  out  1  run in progress.
- done  out  1  run finished; held high.
- pass  out  1  valid when done is high; 1 means zero mismatches.
- err_count  out  16  mismatch count, saturating.
- first_err_idx  out  AW  index of the first mismatching vector.
- first_err_got  out  OUT_W  dut_out value captured at the first mismatch.

Function
REQ-006 SHALL use four states: IDLE, RUN, DRAIN, DONE.
REQ-007 SHALL write the memory on ld_we only in IDLE or DONE; ld_we in RUN or DRAIN is ignored.
REQ-008 SHALL act on start only in IDLE or DONE; start clears err_count, first_err_*, done and pass, latches num_vec, and moves to RUN.
REQ-009 SHALL move from IDLE or DONE directly to DONE with pass=1 and err_count=0 when start occurs with num_vec=0.
REQ-010 SHALL clamp a sampled num_vec greater than DEPTH to DEPTH.
REQ-011 SHALL drive dut_in = stim[k] during cycle t+1+k, where t is the start cycle, for k = 0..N-1.
REQ-012 SHALL compare vector k against dut_out sampled in cycle t+1+k+LAT, using an expected/mask/index pipeline LAT stages deep (LAT=0 compares in the same cycle).
REQ-013 SHALL count a mismatch when ((dut_out ^ expected) & mask) != 0.
REQ-014 SHALL increment err_count by one per mismatching vector and saturate at 0xFFFF.
REQ-015 SHALL capture first_err_idx and first_err_got only on the first mismatch of a run.
REQ-016 SHALL move RUN -> DRAIN after the last vector is applied, holding dut_in at stim[N-1].
REQ-017 SHALL leave DRAIN after LAT compares and enter DONE; when LAT=0, RUN goes directly to DONE.
REQ-018 SHALL assert done the cycle after the final compare, with pass = (err_count==0).
REQ-019 SHALL hold done and all result outputs stable in DONE until the next start.
REQ-020 SHALL assert busy exactly in RUN and DRAIN.
REQ-021 SHALL, on abort in RUN or DRAIN, flush the compare pipeline and move to IDLE with done=0; compares still in flight are discarded and already-counted errors are kept.
REQ-022 SHALL ignore abort in IDLE and DONE.
REQ-023 SHALL give abort priority over start when both are asserted in the same cycle.

Reset
REQ-024 SHALL, while reset=0, force state=IDLE, dut_in=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, first_err_got=0, and clear the compare pipeline.
REQ-025 SHALL NOT reset vector memory contents.
REQ-026 SHALL treat a reset during a run as a full abort, with no result retained.

Configuration
REQ-027 SHALL compile masking in when TV_CHECKER_MASK_EN is defined; the mask field of each vector is stored and applied.
REQ-028 SHALL, without TV_CHECKER_MASK_EN, treat the mask as all-ones, store no mask bits, and ignore the mask bits of ld_data; the ld_data width does not change.

Verification (IN_W=4, OUT_W=4, DEPTH=8, LAT=1, DUT = register of dut_in)
REQ-029 SHALL cover: load 8 vectors with expected == stim, num_vec=8, start -> done rises 10 cycles after start with pass=1 and err_count=0.
REQ-030 SHALL cover: vector 3 expected corrupted to 4'hF, stim=4'h3 -> err_count=1, first_err_idx=3, first_err_got=4'h3, pass=0.
REQ-031 SHALL cover, with TV_CHECKER_MASK_EN: vector 3 mask=4'h0 with a corrupted expected -> pass=1; without the macro -> err_count=1.
REQ-032 SHALL cover: num_vec=0 then start -> done=1 and pass=1 the next cycle; num_vec=12 -> exactly 8 vectors applied.
REQ-033 SHALL cover: abort in cycle t+4 -> busy=0 and done=0 the next cycle; ld_we during RUN leaves memory unchanged.
REQ-034 SHALL cover: reset asserted mid-RUN -> all outputs 0 immediately, then a fresh run passes.

Source files
------------

// File: rtl/tv_checker_if.sv
// tv_checker_if: load, control, DUT-facing and result signals of tv_checker.
// The host/testbench side uses master; tv_checker uses slave.
interface tv_checker_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 8,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);
    logic                    ld_we;
    logic [AW-1:0]           ld_addr;
    logic [IN_W+2*OUT_W-1:0] ld_data;
    logic [AW:0]             num_vec;
    logic                    start;
    logic                    abort;
    logic [IN_W-1:0]         dut_in;
    logic [OUT_W-1:0]        dut_out;
    logic                    busy;
    logic                    done;
    logic                    pass;
    logic [15:0]             err_count;
    logic [AW-1:0]           first_err_idx;
    logic [OUT_W-1:0]        first_err_got;
    modport master (
        output ld_we, ld_addr, ld_data, num_vec, start, abort, dut_out,
        input  dut_in, busy, done, pass, err_count, first_err_idx, first_err_got
    );
    modport slave (
        input  ld_we, ld_addr, ld_data, num_vec, start, abort, dut_out,
        output dut_in, busy, done, pass, err_count, first_err_idx, first_err_got
    );
endinterface

// File: rtl/tv_checker.sv
// tv_checker: replays stored stimulus into a DUT and checks its delayed responses.
// Define TV_CHECKER_MASK_EN to store and apply the per-vector compare mask.
module tv_checker #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 8,
    parameter int DEPTH = 16,
    parameter int LAT   = 1
) (
    input logic          clk,
    input logic          reset,
    tv_checker_if.slave  ifc
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t           state_q;
    logic [IN_W-1:0]  stim_mem [DEPTH];
    logic [OUT_W-1:0] exp_mem [DEPTH];
    logic [AW:0]      n_q, k_q, n_clamp;
    logic [2:0]       dr_q;
    logic [IN_W-1:0]  dut_in_q;
    logic             done_q, pass_q;
    logic [15:0]      err_q, err_d;
    logic [AW-1:0]    first_idx_q;
    logic [OUT_W-1:0] first_got_q;
    logic [OUT_W-1:0] exp_q [LAT+1];
    logic [OUT_W-1:0] msk_q [LAT+1];
    logic [AW-1:0]    idx_q [LAT+1];
    logic             vld_q [LAT+1];
    logic [AW-1:0]    rd_addr;
    logic [OUT_W-1:0] msk_rd;
    logic             idle_like, active, go, load, miss;
`ifdef TV_CHECKER_MASK_EN
    logic [OUT_W-1:0] msk_mem [DEPTH];
    assign msk_rd = msk_mem[rd_addr];
`else
    logic unused_msk;
    assign msk_rd     = '1;
    assign unused_msk = ^ifc.ld_data[OUT_W-1:0];
`endif
    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign active    = (state_q == RUN) || (state_q == DRAIN);
    assign go        = idle_like && ifc.start && !ifc.abort;
    assign n_clamp   = (ifc.num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : ifc.num_vec;
    assign rd_addr   = (state_q == RUN) ? k_q[AW-1:0] : '0;
    assign load      = (go && n_clamp != '0) || (state_q == RUN && !ifc.abort && k_q < n_q);
    // The compare point is the last pipeline stage; stage 0 lines up with dut_in.
    assign miss      = active && !ifc.abort && vld_q[LAT] &&
                       (((ifc.dut_out ^ exp_q[LAT]) & msk_q[LAT]) != '0);
    assign err_d     = err_q + 16'(miss && err_q != 16'hFFFF);
    always_ff @(posedge clk) begin
        if (ifc.ld_we && idle_like) begin
            stim_mem[ifc.ld_addr] <= ifc.ld_data[IN_W+2*OUT_W-1 -: IN_W];
            exp_mem[ifc.ld_addr]  <= ifc.ld_data[2*OUT_W-1 -: OUT_W];
`ifdef TV_CHECKER_MASK_EN
            msk_mem[ifc.ld_addr]  <= ifc.ld_data[OUT_W-1:0];
`endif
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            k_q         <= '0;
            dr_q        <= '0;
            dut_in_q    <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            first_idx_q <= '0;
            first_got_q <= '0;
            for (int i = 0; i <= LAT; i++) begin
                vld_q[i] <= 1'b0;
                exp_q[i] <= '0;
                msk_q[i] <= '0;
                idx_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= load;
            for (int i = 1; i <= LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                exp_q[i] <= exp_q[i-1];
                msk_q[i] <= msk_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
            if (load) begin
                dut_in_q <= stim_mem[rd_addr];
                exp_q[0] <= exp_mem[rd_addr];
                msk_q[0] <= msk_rd;
                idx_q[0] <= rd_addr;
                k_q      <= k_q + 1'b1;
            end
            if (miss) begin
                err_q <= err_d;
                if (err_q == 16'd0) begin
                    first_idx_q <= idx_q[LAT];
                    first_got_q <= ifc.dut_out;
                end
            end
            if (active && ifc.abort) begin
                state_q <= IDLE;
                for (int i = 0; i <= LAT; i++) vld_q[i] <= 1'b0;
            end else if (go) begin
                n_q         <= n_clamp;
                k_q         <= (AW+1)'(1);
                err_q       <= '0;
                first_idx_q <= '0;
                first_got_q <= '0;
                done_q      <= n_clamp == '0;
                pass_q      <= n_clamp == '0;
                state_q     <= (n_clamp == '0) ? DONE : RUN;
            end else if (state_q == RUN && k_q == n_q) begin
                dr_q    <= 3'(LAT - 1);
                state_q <= (LAT == 0) ? DONE : DRAIN;
                done_q  <= LAT == 0;
                pass_q  <= (LAT == 0) && err_d == 16'd0;
            end else if (state_q == DRAIN) begin
                dr_q    <= dr_q - 1'b1;
                state_q <= (dr_q == '0) ? DONE : DRAIN;
                done_q  <= dr_q == '0;
                pass_q  <= (dr_q == '0) && err_d == 16'd0;
            end
        end
    end
    assign ifc.dut_in        = dut_in_q;
    assign ifc.busy          = active;
    assign ifc.done          = done_q;
    assign ifc.pass          = pass_q;
    assign ifc.err_count     = err_q;
    assign ifc.first_err_idx = first_idx_q;
    assign ifc.first_err_got = first_got_q;
endmodule
